// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer state and register indices.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef logic [3:0] reg_idx_t;

  // A source conflicts with a producer only when the producer actually writes back.
  function automatic logic src_hit(input reg_idx_t src, input reg_idx_t dest, input logic wb_en);
    return wb_en && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller; master = pipeline, slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  import pipeline_hazard_ctrl_pkg::*;

  logic             forward_en;
  logic             id_valid;
  reg_idx_t         src1;
  reg_idx_t         src2;
  logic             two_src;
  reg_idx_t         exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  reg_idx_t         mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             hazard_stall;
  logic             flush;
  logic             freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output forward_en, id_valid, src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  hazard_stall, flush, freeze, mem_err, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  forward_en, id_valid, src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output hazard_stall, flush, freeze, mem_err, stall_cnt, flush_cnt, freeze_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline with saturating event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            pend_flush_q, pend_flush_d;

  logic raw1, raw2, ld1, ld2, haz;
  logic freeze, flush, hazard_stall;

  // Hazard detection: load-use only when forwarding covers the rest.
  always_comb begin
    raw1 = bus.id_valid && (src_hit(bus.src1, bus.exe_dest, bus.exe_wb_en) ||
                            src_hit(bus.src1, bus.mem_dest, bus.mem_wb_en));
    raw2 = bus.id_valid && bus.two_src &&
           (src_hit(bus.src2, bus.exe_dest, bus.exe_wb_en) ||
            src_hit(bus.src2, bus.mem_dest, bus.mem_wb_en));
    ld1  = bus.id_valid && bus.exe_mem_r_en && src_hit(bus.src1, bus.exe_dest, bus.exe_wb_en);
    ld2  = bus.id_valid && bus.two_src && bus.exe_mem_r_en &&
           src_hit(bus.src2, bus.exe_dest, bus.exe_wb_en);
    haz  = bus.forward_en ? (ld1 || ld2) : (raw1 || raw2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LIMIT) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Freeze dominates; a branch seen while frozen is replayed as one flush on release.
  always_comb begin
    freeze = 1'b0;
    unique case (state_q)
      RUN:     freeze = bus.mem_req && !bus.mem_ready;
      WAIT:    freeze = !bus.mem_ready && (wait_cnt_q != WC_LIMIT);
      default: freeze = 1'b0;
    endcase
    flush        = !freeze && (bus.branch_taken || pend_flush_q);
    hazard_stall = !freeze && !flush && haz;
    pend_flush_d = freeze && (pend_flush_q || bus.branch_taken);
  end

  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hazard_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze),
    .count (freeze_cnt)
  );

  // Combinational outputs are masked so reset silences them without waiting for a clock.
  assign bus.freeze       = freeze && rst;
  assign bus.flush        = flush && rst;
  assign bus.hazard_stall = hazard_stall && rst;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;
  assign bus.freeze_cnt   = freeze_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of the hazard controller against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 6;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: m_wait = 0 when not waiting, else cycles spent waiting so far.
  int m_wait;
  bit m_pend, m_err;
  int m_stall, m_flush, m_freeze;
  bit last_stall, last_flush, last_freeze;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit conflict(input logic [3:0] s);
    if (bus.forward_en)
      return bus.exe_mem_r_en && bus.exe_wb_en && (s == bus.exe_dest);
    return (bus.exe_wb_en && (s == bus.exe_dest)) || (bus.mem_wb_en && (s == bus.mem_dest));
  endfunction

  function automatic bit model_haz();
    if (!bus.id_valid) return 1'b0;
    return conflict(bus.src1) || (bus.two_src && conflict(bus.src2));
  endfunction

  function automatic bit model_freeze();
    if (m_wait == 0) return bus.mem_req && !bus.mem_ready;
    return !bus.mem_ready && (m_wait < TIMEOUT);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic idle_inputs();
    bus.forward_en = 1'b0; bus.id_valid = 1'b0; bus.src1 = '0; bus.src2 = '0;
    bus.two_src = 1'b0; bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
    bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_err = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freeze"}, bus.freeze, 0);
    check({tag, "_flush"}, bus.flush, 0);
    check({tag, "_stall"}, bus.hazard_stall, 0);
    check({tag, "_err"}, bus.mem_err, 0);
    check({tag, "_stall_cnt"}, bus.stall_cnt, 0);
    check({tag, "_flush_cnt"}, bus.flush_cnt, 0);
    check({tag, "_freeze_cnt"}, bus.freeze_cnt, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One cycle: check combinational outputs mid-cycle, advance model at the edge, check state.
  task automatic step();
    bit fz, fl, st;
    #2;
    fz = model_freeze();
    fl = !fz && (bus.branch_taken || m_pend);
    st = !fz && !fl && model_haz();
    last_freeze = bus.freeze;
    last_flush  = bus.flush;
    last_stall  = bus.hazard_stall;
    check("freeze", bus.freeze, fz);
    check("flush", bus.flush, fl);
    check("hazard_stall", bus.hazard_stall, st);
    @(posedge clk);
    m_pend = fz ? (m_pend || bus.branch_taken) : 1'b0;
    if (m_wait == 0) begin
      if (bus.mem_req && !bus.mem_ready) m_wait = 1;
    end else if (bus.mem_ready) begin
      m_wait = 0;
    end else if (m_wait == TIMEOUT) begin
      m_err = 1; m_wait = 0;
    end else begin
      m_wait++;
    end
    if (st) m_stall = sat_inc(m_stall);
    if (fl) m_flush = sat_inc(m_flush);
    if (fz) m_freeze = sat_inc(m_freeze);
    #1;
    check("mem_err", bus.mem_err, m_err);
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("flush_cnt", bus.flush_cnt, m_flush);
    check("freeze_cnt", bus.freeze_cnt, m_freeze);
  endtask

  initial begin
    int n;
    model_reset();
    idle_inputs();
    do_reset();

    // Load-use with forwarding: one stall, then the load has moved to MEM.
    bus.forward_en = 1; bus.id_valid = 1; bus.src1 = 4'd3; bus.src2 = 4'd7;
    bus.exe_dest = 4'd3; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
    step();
    check("ld_use_stall", last_stall, 1);
    bus.exe_wb_en = 0; bus.exe_mem_r_en = 0; bus.mem_dest = 4'd3; bus.mem_wb_en = 1;
    step();
    check("ld_use_release", last_stall, 0);
    check("ld_use_cnt", bus.stall_cnt, 1);

    // RAW without forwarding on src2, gated by two_src; r0 is not special.
    idle_inputs();
    bus.id_valid = 1; bus.src1 = 4'd9; bus.src2 = 4'd5; bus.two_src = 1;
    bus.mem_dest = 4'd5; bus.mem_wb_en = 1;
    step();
    check("raw_src2_stall", last_stall, 1);
    bus.two_src = 0;
    step();
    check("raw_src2_gated", last_stall, 0);
    idle_inputs();
    bus.id_valid = 1; bus.src1 = 4'd0; bus.exe_dest = 4'd0; bus.exe_wb_en = 1;
    step();
    check("raw_r0_stall", last_stall, 1);

    // SRAM ready after 4 cycles: 4 freeze cycles.
    do_reset();
    bus.mem_req = 1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin bus.mem_req = 0; bus.mem_ready = 1; end
      if (i == 5) bus.mem_ready = 0;
      step();
      n += int'(last_freeze);
      if (i == 4) check("freeze_release", last_freeze, 0);
    end
    check("freeze_cycles", n, 4);
    check("freeze_cnt_4", bus.freeze_cnt, 4);

    // Branch while frozen: deferred, merged with a branch in the release cycle.
    do_reset();
    bus.mem_req = 1;
    step();
    bus.mem_req = 0; bus.branch_taken = 1;
    step();
    check("flush_held_in_freeze", last_flush, 0);
    bus.branch_taken = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus.mem_ready = 1; bus.branch_taken = 1; end
      if (i == 3) begin bus.mem_ready = 0; bus.branch_taken = 0; end
      step();
      n += int'(last_flush);
      if (i == 2) check("flush_on_release", last_flush, 1);
    end
    check("flush_pulses", n, 1);
    check("flush_cnt_1", bus.flush_cnt, 1);

    // SRAM never ready: freeze lasts TIMEOUT cycles, mem_err becomes sticky.
    do_reset();
    bus.mem_req = 1;
    step();
    bus.mem_req = 0;
    n = int'(last_freeze);
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      step();
      if (!last_freeze) break;
      n++;
    end
    check("timeout_freeze_cycles", n, TIMEOUT);
    check("timeout_err", bus.mem_err, 1);
    repeat (5) step();
    check("err_sticky", bus.mem_err, 1);

    // Drive every counter into saturation, then reset asynchronously mid-WAIT.
    do_reset();
    bus.id_valid = 1; bus.src1 = 4'd2; bus.exe_dest = 4'd2; bus.exe_wb_en = 1;
    repeat (CMAX + 5) step();
    idle_inputs();
    bus.branch_taken = 1;
    repeat (CMAX + 5) step();
    idle_inputs();
    bus.mem_req = 1;
    step();
    bus.mem_req = 0;
    repeat (TIMEOUT + 2) step();
    check("sat_stall", bus.stall_cnt, CMAX);
    check("sat_flush", bus.flush_cnt, CMAX);
    check("sat_freeze", bus.freeze_cnt, CMAX);
    bus.mem_req = 1;
    repeat (3) step();
    bus.branch_taken = 1; bus.id_valid = 1; bus.src1 = 4'd2; bus.exe_dest = 4'd2; bus.exe_wb_en = 1;
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("post_rst_run", bus.freeze, 0);
    @(posedge clk);
    #1;

    // Randomized traffic, restarted from reset a few times so counts grow from zero.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        bus.forward_en   = ($urandom_range(0, 1) == 1);
        bus.id_valid     = ($urandom_range(0, 9) < 8);
        bus.src1         = 4'($urandom_range(0, 3));
        bus.src2         = 4'($urandom_range(0, 3));
        bus.two_src      = ($urandom_range(0, 1) == 1);
        bus.exe_dest     = 4'($urandom_range(0, 3));
        bus.exe_wb_en    = ($urandom_range(0, 2) != 0);
        bus.exe_mem_r_en = ($urandom_range(0, 2) == 0);
        bus.mem_dest     = 4'($urandom_range(0, 3));
        bus.mem_wb_en    = ($urandom_range(0, 1) == 1);
        bus.branch_taken = ($urandom_range(0, 6) == 0);
        bus.mem_req      = ($urandom_range(0, 4) == 0);
        bus.mem_ready    = (blk == 3) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 4) < 2);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
